// File: rtl/system.sv
// Teaching-processor top: clock-enable divider pacing a single-cycle 16-bit CPU
// running a fixed ROM program, with a selectable debug view on the LED bus.
module system #(
  parameter int unsigned divisor = 1
) (
  input  logic        clk,
  input  logic        SYS_reset,
  input  logic [2:0]  SYS_output_sel,
  output logic [26:0] SYS_leds
);

  localparam int unsigned CW = (divisor > 1) ? $clog2(divisor) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(divisor - 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_BEQ  = 4'd5,
    OP_J    = 4'd6
  } opcode_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          step;
  logic [7:0]    pc_q, pc_d;
  logic [15:0]   regs_q [8];
  logic [15:0]   instr;
  logic [2:0]    rd, rs, rt;
  logic [15:0]   imm16;
  logic [15:0]   rd_val, rs_val, rt_val;
  logic          wr_en;
  logic [15:0]   wr_val;

  always_comb begin
    instr = '0;
    unique case (pc_q)
      8'd0:    instr = 16'h4205;
      8'd1:    instr = 16'h4403;
      8'd2:    instr = 16'h0650;
      8'd3:    instr = 16'h1850;
      8'd4:    instr = 16'h427F;
      8'd5:    instr = 16'h5201;
      8'd6:    instr = 16'h6004;
      8'd7:    instr = 16'h6007;
      default: instr = 16'h0000;
    endcase
  end

  assign rd     = instr[11:9];
  assign rs     = instr[8:6];
  assign rt     = instr[5:3];
  assign imm16  = {{10{instr[5]}}, instr[5:0]};
  // r0 is forced to read zero regardless of its storage
  assign rd_val = (rd == 3'd0) ? '0 : regs_q[rd];
  assign rs_val = (rs == 3'd0) ? '0 : regs_q[rs];
  assign rt_val = (rt == 3'd0) ? '0 : regs_q[rt];

  assign step  = (cnt_q == CNT_LAST);
  assign cnt_d = step ? '0 : cnt_q + CW'(1);

  always_comb begin
    pc_d   = pc_q + 8'd1;
    wr_en  = 1'b0;
    wr_val = '0;
    case (opcode_e'(instr[15:12]))
      OP_ADD:  begin wr_en = 1'b1; wr_val = rs_val + rt_val; end
      OP_SUB:  begin wr_en = 1'b1; wr_val = rs_val - rt_val; end
      OP_AND:  begin wr_en = 1'b1; wr_val = rs_val & rt_val; end
      OP_OR:   begin wr_en = 1'b1; wr_val = rs_val | rt_val; end
      OP_ADDI: begin wr_en = 1'b1; wr_val = rs_val + imm16; end
      OP_BEQ:  if (rd_val == rs_val) pc_d = pc_q + 8'd1 + imm16[7:0];
      OP_J:    pc_d = instr[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!SYS_reset) begin
      cnt_q <= '0;
      pc_q  <= '0;
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (step) begin
        pc_q <= pc_d;
        if (wr_en && (rd != 3'd0)) regs_q[rd] <= wr_val;
      end
    end
  end

  assign SYS_leds = (SYS_output_sel == 3'd0) ? {3'b000, pc_q, instr}
                                             : {11'd0, regs_q[SYS_output_sel]};

endmodule

// File: tb/tb_system.sv
// Directed bench for system: instruction-level reference model feeds a queue of
// expected LED views, popped and compared after each clock edge.
module tb_system;

  logic        clk = 1'b0;
  logic        rst1, rst4;
  logic [2:0]  sel1, sel4;
  logic [26:0] leds1, leds4;

  always #10 clk = ~clk;

  system #(.divisor(1)) u1 (
    .clk(clk), .SYS_reset(rst1), .SYS_output_sel(sel1), .SYS_leds(leds1)
  );
  system #(.divisor(4)) u4 (
    .clk(clk), .SYS_reset(rst4), .SYS_output_sel(sel4), .SYS_leds(leds4)
  );

  int total = 0;
  int bad   = 0;
  logic [26:0] sbq [$];

  logic [7:0]  m_pc;
  logic [15:0] m_r [8];

  function automatic logic [15:0] m_rom(input logic [7:0] a);
    case (a)
      8'd0: return 16'h4205;
      8'd1: return 16'h4403;
      8'd2: return 16'h0650;
      8'd3: return 16'h1850;
      8'd4: return 16'h427F;
      8'd5: return 16'h5201;
      8'd6: return 16'h6004;
      8'd7: return 16'h6007;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_reset();
    m_pc = 8'd0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
  endtask

  task automatic m_step();
    logic [15:0] ins, a, b, c, imm, res;
    int d;
    logic wr;
    ins = m_rom(m_pc);
    d   = int'(ins[11:9]);
    a   = m_r[ins[11:9]];
    b   = m_r[ins[8:6]];
    c   = m_r[ins[5:3]];
    imm = 16'($signed(ins[5:0]));
    wr  = 1'b1;
    res = 16'd0;
    case (ins[15:12])
      4'd0: res = b + c;
      4'd1: res = b - c;
      4'd2: res = b & c;
      4'd3: res = b | c;
      4'd4: res = b + imm;
      default: wr = 1'b0;
    endcase
    if (ins[15:12] == 4'd5 && a == b) m_pc = m_pc + 8'd1 + imm[7:0];
    else if (ins[15:12] == 4'd6)      m_pc = ins[7:0];
    else                              m_pc = m_pc + 8'd1;
    if (wr && d != 0) m_r[d] = res;
  endtask

  task automatic m_push();
    sbq.push_back({3'b000, m_pc, m_rom(m_pc)});
    for (int s = 1; s < 8; s++) sbq.push_back({11'd0, m_r[s]});
  endtask

  task automatic check(input logic [26:0] obs, input logic [26:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [26:0] exp;
    for (int s = 0; s < 8; s++) begin
      sel1 = 3'(s);
      #1;
      exp = sbq.pop_front();
      check(leds1, exp, $sformatf("%s sel%0d", tag, s));
    end
  endtask

  task automatic check_const(input logic [2:0] s, input logic [26:0] exp, input string tag);
    sbq.push_back(exp);
    sel1 = s;
    #1;
    check(leds1, sbq.pop_front(), tag);
  endtask

  task automatic check4(input logic [2:0] s, input logic [26:0] exp, input string tag);
    sel4 = s;
    #1;
    check(leds4, exp, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input string tag);
    tick();
    m_step();
    m_push();
    check_sb(tag);
  endtask

  initial begin
    rst1 = 1'b0; rst4 = 1'b0; sel1 = 3'd0; sel4 = 3'd0;
    m_reset();

    tick();
    m_push();
    check_sb("reset");
    check_const(3'd0, 27'h0004205, "reset pc view");
    check4(3'd0, 27'h0004205, "u4 reset pc view");
    rst1 = 1'b1; rst4 = 1'b1;

    for (int k = 1; k <= 8; k++) begin
      step1($sformatf("run step%0d", k));
      if (k < 4) begin
        check4(3'd0, 27'h0004205, $sformatf("u4 edge%0d pc view", k));
        check4(3'd1, 27'h0, $sformatf("u4 edge%0d r1", k));
      end
      if (k == 4) begin
        check4(3'd0, 27'h0014403, "u4 edge4 pc view");
        check4(3'd1, 27'd5, "u4 edge4 r1");
        check_const(3'd1, 27'd5, "step4 r1");
        check_const(3'd2, 27'd3, "step4 r2");
        check_const(3'd3, 27'd8, "step4 r3");
        check_const(3'd4, 27'd2, "step4 r4");
        check_const(3'd0, 27'h004427F, "step4 pc view");
      end
      if (k == 8) check4(3'd0, 27'h0020650, "u4 edge8 pc view");
    end

    for (int k = 9; k <= 18; k++) step1($sformatf("run step%0d", k));
    check_const(3'd0, 27'h0076007, "step18 pc view");
    check_const(3'd1, 27'd0, "step18 r1");

    for (int k = 19; k <= 28; k++) step1($sformatf("halt step%0d", k));
    check_const(3'd0, 27'h0076007, "halt pc view");
    check_const(3'd1, 27'd0, "halt r1");
    check_const(3'd2, 27'd3, "halt r2");
    check_const(3'd3, 27'd8, "halt r3");
    check_const(3'd4, 27'd2, "halt r4");

    rst1 = 1'b0;
    tick();
    m_reset(); m_push(); check_sb("rerun reset");
    rst1 = 1'b1;
    for (int k = 1; k <= 10; k++) step1($sformatf("pre-mid step%0d", k));

    rst1 = 1'b0;
    tick();
    m_reset(); m_push(); check_sb("mid reset");
    check_const(3'd0, 27'h0004205, "mid reset pc view");
    rst1 = 1'b1;

    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 5) begin
        #2 rst1 = 1'b0;
        #2 rst1 = 1'b1;
      end
      m_step(); m_push();
      check_sb($sformatf("post-mid step%0d", k));
    end
    check_const(3'd0, 27'h0076007, "post-mid pc view");
    check_const(3'd3, 27'd8, "post-mid r3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
